network_run_ctrl: RTL and testbench

- Instruction-driven scheduler placed between a host instruction stream and the network's input handshake.
- Accepts SPK, RUN, CLR and NOP instructions.
- SPK instructions accumulate input charges into a pending vector.
- A RUN of k issues k timestep beats to the network. The pending charges go out on the first beat, zeros on the rest, and `net_last` marks the final beat. CLR produces a one-cycle network reset pulse.

---
 rtl/network_run_ctrl_pkg.sv | 33 +++
 rtl/network_run_ctrl_sat_add.sv | 26 ++
 rtl/network_run_ctrl.sv | 127 ++++++++++++
 tb/tb_network_run_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/network_run_ctrl_pkg.sv
// ctrl_config: shared types and default sizing for network_run_ctrl.
//   ctrl_opcode_t    : 2-bit instruction opcode (NOP/RUN/SPK/CLR)
//   ctrl_state_t     : scheduler FSM state (IDLE/RUN/CLEAR)
//   CTRL_*_WIDTH     : instruction field widths for the default configuration
//   DEF_*            : default values of the top-level parameters
package ctrl_config;

  localparam int DEF_NUM_INP      = 4;
  localparam int DEF_CHARGE_WIDTH = 8;
  localparam int DEF_RUN_WIDTH    = 8;

  localparam int CTRL_OPC_WIDTH = 2;
  // A single-input network still needs one index bit in the SPK argument.
  localparam int IDX_WIDTH = (DEF_NUM_INP > 1) ? $clog2(DEF_NUM_INP) : 1;
  localparam int CTRL_ARG_WIDTH =
    (DEF_RUN_WIDTH > IDX_WIDTH + DEF_CHARGE_WIDTH) ? DEF_RUN_WIDTH
                                                   : IDX_WIDTH + DEF_CHARGE_WIDTH;
  localparam int CTRL_INSTR_WIDTH = CTRL_OPC_WIDTH + CTRL_ARG_WIDTH;

  typedef enum logic [1:0] {
    OPC_NOP = 2'd0,
    OPC_RUN = 2'd1,
    OPC_SPK = 2'd2,
    OPC_CLR = 2'd3
  } ctrl_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/network_run_ctrl_sat_add.sv
// sat_add: combinational signed saturating adder.
//   i_a, i_b : signed WIDTH-bit operands
//   o_sum    : i_a + i_b clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]
module sat_add #(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  output logic signed [WIDTH-1:0] o_sum
);

  logic signed [WIDTH:0] w_full;

  assign w_full = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

  // Overflow shows up as the two top bits of the sign-extended sum
  // disagreeing; the extra top bit then carries the true sign.
  always_comb begin
    o_sum = w_full[WIDTH-1:0];
    if (w_full[WIDTH] != w_full[WIDTH-1]) begin
      o_sum = w_full[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                            : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/network_run_ctrl.sv
// network_run_ctrl: instruction-driven scheduler between a host instruction
// stream and a network's timestep input handshake.
//   clk, arstn          : clock, asynchronous active-low reset
//   instr_valid/ready   : instruction handshake, instr = {opc[1:0], arg}
//   net_valid/ready     : timestep beat handshake, net_last marks final beat
//   net_inp             : per-input charge (two's complement lanes)
//   net_arstn           : active-low network reset (reset or CLR pulse)
//   busy                : scheduler not idle
//   dbg_state           : current FSM state
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; while valid is high and ready low the sender holds its
// payload stable, and valid never drops without a transfer except on reset.
module network_run_ctrl
  import ctrl_config::*;
#(
  parameter  int NUM_INP      = DEF_NUM_INP,
  parameter  int CHARGE_WIDTH = DEF_CHARGE_WIDTH,
  parameter  int RUN_WIDTH    = DEF_RUN_WIDTH,
  localparam int IDX_W        = (NUM_INP > 1) ? $clog2(NUM_INP) : 1,
  localparam int ARG_W        = (RUN_WIDTH > IDX_W + CHARGE_WIDTH) ? RUN_WIDTH
                                                                   : IDX_W + CHARGE_WIDTH,
  localparam int INSTR_W      = CTRL_OPC_WIDTH + ARG_W
) (
  input  logic                                    clk,
  input  logic                                    arstn,
  input  logic                                    instr_valid,
  output logic                                    instr_ready,
  input  logic [INSTR_W-1:0]                      instr,
  output logic                                    net_valid,
  input  logic                                    net_ready,
  output logic                                    net_last,
  output logic                                    net_arstn,
  output logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]    net_inp,
  output logic                                    busy,
  output ctrl_state_t                             dbg_state
);

  ctrl_state_t                              r_state;
  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]     r_pending;
  logic [RUN_WIDTH-1:0]                     r_count;
  logic                                     r_first;
  logic                                     r_clr;

  ctrl_opcode_t                             w_opc;
  logic [CHARGE_WIDTH-1:0]                  w_charge;
  logic [IDX_W-1:0]                         w_idx;
  logic [RUN_WIDTH-1:0]                     w_run_cnt;
  logic                                     w_accept;
  logic [NUM_INP-1:0][CHARGE_WIDTH-1:0]     w_sum;

  assign w_opc     = ctrl_opcode_t'(instr[INSTR_W-1 -: CTRL_OPC_WIDTH]);
  assign w_charge  = instr[CHARGE_WIDTH-1:0];
  assign w_idx     = instr[CHARGE_WIDTH +: IDX_W];
  assign w_run_cnt = instr[RUN_WIDTH-1:0];
  assign w_accept  = instr_valid && instr_ready;

  for (genvar g = 0; g < NUM_INP; g++) begin : g_lane
    sat_add #(.WIDTH(CHARGE_WIDTH)) u_sat_add (
      .i_a   (r_pending[g]),
      .i_b   (w_charge),
      .o_sum (w_sum[g])
    );
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_count   <= '0;
      r_first   <= 1'b0;
      r_clr     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_opc)
              OPC_SPK: begin
                // An index with no matching lane simply writes nothing.
                for (int i = 0; i < NUM_INP; i++) begin
                  if (w_idx == IDX_W'(i)) r_pending[i] <= w_sum[i];
                end
              end
              OPC_RUN: begin
                if (w_run_cnt != '0) begin
                  r_count <= w_run_cnt;
                  r_first <= 1'b1;
                  r_state <= ST_RUN;
                end
              end
              OPC_CLR: begin
                r_clr     <= 1'b1;
                r_pending <= '0;
                r_state   <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (net_ready) begin
            r_count <= r_count - 1'b1;
            r_first <= 1'b0;
            // Charges are delivered once; later beats carry zeros.
            if (r_first) r_pending <= '0;
            if (r_count == RUN_WIDTH'(1)) r_state <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          r_clr   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // instr_ready is gated by arstn so nothing is offered while held in reset.
  assign instr_ready = arstn && (r_state == ST_IDLE);
  assign net_valid   = (r_state == ST_RUN);
  assign net_last    = net_valid && (r_count == RUN_WIDTH'(1));
  assign net_inp     = (net_valid && r_first) ? r_pending : '0;
  assign net_arstn   = arstn && !r_clr;
  assign busy        = (r_state != ST_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_network_run_ctrl.sv
module tb_network_run_ctrl;
  import ctrl_config::*;

  localparam int NI = DEF_NUM_INP;
  localparam int CW = DEF_CHARGE_WIDTH;
  localparam int RW = DEF_RUN_WIDTH;
  localparam int AW = CTRL_ARG_WIDTH;
  localparam int IW = CTRL_INSTR_WIDTH;
  localparam int BW = NI * CW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic instr_valid = 1'b0;
  logic net_ready = 1'b1;
  logic [IW-1:0] instr = '0;
  logic instr_ready, net_valid, net_last, net_arstn, busy;
  logic [NI-1:0][CW-1:0] net_inp;
  ctrl_state_t dbg_state;

  always #5 clk = ~clk;

  network_run_ctrl dut (
    .clk         (clk),
    .arstn       (arstn),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .net_valid   (net_valid),
    .net_ready   (net_ready),
    .net_last    (net_last),
    .net_arstn   (net_arstn),
    .net_inp     (net_inp),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [BW-1:0] exp_q[$];      // {last, inp} per expected beat
  int pend_m[NI];
  bit clr_due, run_due, prev_stall;
  logic [BW-1:0] prev_beat;
  int hs_cnt = 0;

  function automatic int sat(input int v);
    if (v > (1 << (CW - 1)) - 1) return (1 << (CW - 1)) - 1;
    if (v < -(1 << (CW - 1))) return -(1 << (CW - 1));
    return v;
  endfunction

  task automatic model_accept(input logic [IW-1:0] ins);
    int opc, idx, chg, cnt;
    logic [NI*CW-1:0] vec;
    opc = int'(ins[IW-1 -: 2]);
    chg = int'($signed(ins[CW-1:0]));
    idx = int'(ins[CW +: IDX_WIDTH]);
    cnt = int'(ins[RW-1:0]);
    case (opc)
      2: if (idx < NI) pend_m[idx] = sat(pend_m[idx] + chg);
      1: if (cnt > 0) begin
        for (int i = 0; i < NI; i++) vec[i*CW +: CW] = CW'(pend_m[i]);
        for (int b = 0; b < cnt; b++)
          exp_q.push_back({(b == cnt - 1), (b == 0) ? vec : {(NI*CW){1'b0}}});
        for (int i = 0; i < NI; i++) pend_m[i] = 0;
        run_due = 1;
      end
      3: begin
        for (int i = 0; i < NI; i++) pend_m[i] = 0;
        clr_due = 1;
      end
      default: ;
    endcase
  endtask

  // Monitor: inputs change just after posedge, so at negedge both sides of
  // each handshake are settled and the next posedge does exactly this.
  always @(negedge clk) begin
    if (!arstn) begin
      exp_q.delete();
      for (int i = 0; i < NI; i++) pend_m[i] = 0;
      clr_due = 0; run_due = 0; prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold", {net_valid, net_last, net_inp}, {1'b1, prev_beat});
      if (run_due) chk("run_lat", net_valid, 1'b1);
      run_due = 0;
      if (clr_due) begin
        chk("clr_arstn", net_arstn, 1'b0);
        chk("clr_busy", busy, 1'b1);
        clr_due = 0;
      end else begin
        chk("net_arstn_hi", net_arstn, 1'b1);
      end
      if (instr_valid && busy) chk("stall_ready", instr_ready, 1'b0);
      if (exp_q.size() == 0) chk("no_beat", net_valid, 1'b0);
      if (net_valid && net_ready) begin
        hs_cnt++;
        if (exp_q.size() != 0) chk("beat", {net_last, net_inp}, exp_q.pop_front());
      end
      prev_stall = net_valid && !net_ready;
      prev_beat  = {net_last, net_inp};
      if (instr_valid && instr_ready) model_accept(instr);
    end
  end

  // ---------------- drivers ----------------
  bit rdy_mode = 0;   // 0: hold rdy_hold, 1: random
  bit rdy_hold = 1;

  always @(posedge clk) begin
    #2;
    net_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_hold;
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] opc, input logic [AW-1:0] arg);
    int n;
    n = 0;
    instr = {opc, arg};
    instr_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!instr_ready && n < 2000);
    if (!instr_ready) chk("send_timeout", 1'b1, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic spk(input int idx, input int c);
    logic [AW-1:0] a;
    a = '0;
    a[CW-1:0] = CW'(c);
    a[CW +: IDX_WIDTH] = IDX_WIDTH'(idx);
    send(OPC_SPK, a);
  endtask

  task automatic run(input int k);
    send(OPC_RUN, AW'(k));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((busy || exp_q.size() != 0) && n < 3000);
    chk("idle_timeout", (busy || exp_q.size() != 0), 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int h0, n, r;
    logic [AW-1:0] a;

    // reset state
    #1;
    chk("rst_net_arstn", net_arstn, 1'b0);
    chk("rst_ready", instr_ready, 1'b0);
    chk("rst_valid", net_valid, 1'b0);
    chk("rst_last", net_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    repeat (3) @(posedge clk);
    #3 arstn = 1'b1;
    #1;
    chk("rel_net_arstn", net_arstn, 1'b1);
    chk("rel_ready", instr_ready, 1'b1);
    chk("rel_valid", net_valid, 1'b0);
    chk("rel_busy", busy, 1'b0);
    @(posedge clk); #1;

    // accumulate and run 3 beats
    spk(1, 5); spk(1, 7); spk(3, -3);
    run(3);
    chk("run3_beat1", {net_last, net_inp}, {1'b0, 8'hfd, 8'h00, 8'h0c, 8'h00});
    wait_idle();
    run(1);
    chk("pend_zero", {net_last, net_inp}, {1'b1, 32'h0});
    wait_idle();

    // saturation both directions
    spk(0, 100); spk(0, 100); spk(2, -100); spk(2, -100);
    run(1);
    chk("sat_beat", {net_last, net_inp}, {1'b1, 8'h00, 8'h80, 8'h00, 8'h7f});
    wait_idle();

    // backpressure: beat 1 held, NOP stalled until both beats go
    spk(2, 9);
    rdy_hold = 0;
    run(2);
    chk("stall_beat1", {net_last, net_inp}, {1'b0, 8'h00, 8'h09, 8'h00, 8'h00});
    h0 = hs_cnt;
    fork
      send(OPC_NOP, '0);
      begin repeat (5) @(negedge clk); rdy_hold = 1; end
    join
    chk("stall_hs", hs_cnt - h0, 2);
    wait_idle();

    // CLR: one-cycle network reset, pending discarded
    spk(0, 4);
    send(OPC_CLR, '0);
    chk("clr_pulse", net_arstn, 1'b0);
    chk("clr_busy_now", busy, 1'b1);
    run(1);
    chk("clr_beat", {net_last, net_inp}, {1'b1, 32'h0});
    wait_idle();

    // reset in the middle of a 10-beat run
    h0 = hs_cnt;
    run(10);
    n = 0;
    do begin @(posedge clk); n++; end while (hs_cnt - h0 < 4 && n < 100);
    chk("mid_hs", hs_cnt - h0, 4);
    #1 arstn = 1'b0;
    #1;
    chk("mid_valid", net_valid, 1'b0);
    chk("mid_net_arstn", net_arstn, 1'b0);
    chk("mid_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #3 arstn = 1'b1;
    h0 = hs_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("post_rst_hs", hs_cnt - h0, 0);
    chk("post_rst_ready", instr_ready, 1'b1);

    // randomized traffic with random backpressure
    rdy_mode = 1;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      a = AW'($urandom);
      if (r == 0) send(OPC_NOP, a);
      else if (r <= 5) send(OPC_SPK, a);
      else if (r <= 7) begin
        a[RW-1:0] = RW'($urandom_range(0, 5));
        send(OPC_RUN, a);
      end else send(OPC_CLR, a);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();

    // full-range count must not wrap
    rdy_mode = 0;
    rdy_hold = 1;
    h0 = hs_cnt;
    run((1 << RW) - 1);
    wait_idle();
    chk("max_run_hs", hs_cnt - h0, (1 << RW) - 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
